// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and helpers for the push-button conditioner (key_debounce).
//   key_state_e    : per-key debounce FSM state, 2-bit encoding
//   KEY_RELEASED   : raw/debounced level of a released key (active-low pins)
//   KEY_PRESSED    : raw/debounced level of a pressed key
//   cnt_width()    : clog2-based counter width, never below 1 bit
// -----------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [1:0] {
      IDLE_UP   = 2'd0,
      WAIT_DOWN = 2'd1,
      HELD      = 2'd2,
      WAIT_UP   = 2'd3
   } key_state_e;

   localparam logic KEY_RELEASED = 1'b1;
   localparam logic KEY_PRESSED  = 1'b0;

   // Width of a counter that must hold values 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// -----------------------------------------------------------------------------
// key_debounce_cell
// One key channel: two-flop synchroniser, counter-based debounce FSM,
// registered one-cycle press/release pulses and optional long-press pulse.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press counter + fired flag).
// Ports:
//   m_clk      in   system clock, rising edge
//   m_rst      in   synchronous active-high reset
//   key_raw_i  in   asynchronous raw key pin, active-low
//   level_o    out  debounced level, same polarity as the pin
//   press_o    out  one-cycle pulse on debounced 1->0
//   release_o  out  one-cycle pulse on debounced 0->1
//   long_o     out  one-cycle long-press pulse (0 when feature compiled out)
// -----------------------------------------------------------------------------
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic m_clk,
   input  logic m_rst,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // ---------------- synchroniser ----------------
   logic sync1_q, sync2_q;

   always_ff @(posedge m_clk) begin
      if (m_rst) begin
         sync1_q <= KEY_RELEASED;
         sync2_q <= KEY_RELEASED;
      end else begin
         sync1_q <= key_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // ---------------- debounce FSM ----------------
   key_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   always_ff @(posedge m_clk) begin
      if (m_rst) begin
         state_q   <= IDLE_UP;
         cnt_q     <= '0;
         level_q   <= KEY_RELEASED;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         IDLE_UP: begin
            if (sync2_q == KEY_PRESSED) begin
               state_d = WAIT_DOWN;
               cnt_d   = '0;
            end
         end
         WAIT_DOWN: begin
            if (sync2_q == KEY_RELEASED) begin
               state_d = IDLE_UP;          // bounce: drop silently
            end else if (cnt_q == CNT_MAX) begin
               state_d = HELD;
               level_d = KEY_PRESSED;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (sync2_q == KEY_RELEASED) begin
               state_d = WAIT_UP;
               cnt_d   = '0;
            end
         end
         WAIT_UP: begin
            if (sync2_q == KEY_PRESSED) begin
               state_d = HELD;             // bounce: drop silently
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE_UP;
               level_d   = KEY_RELEASED;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE_UP;
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

   // ---------------- optional long-press ----------------
`ifdef KEY_LONG_PRESS_EN
   localparam int LW = cnt_width(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          fired_q, fired_d;
   logic          long_q, long_d;

   always_ff @(posedge m_clk) begin
      if (m_rst) begin
         lcnt_q  <= '0;
         fired_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         lcnt_q  <= lcnt_d;
         fired_q <= fired_d;
         long_q  <= long_d;
      end
   end

   // Counting runs while the key is held or possibly releasing, so a short
   // release bounce (WAIT_UP -> HELD) keeps the accumulated hold time. Outside
   // those states it stays at 0, which gives the clear on entry to HELD.
   // Counting stops once fired, so the counter never wraps.
   always_comb begin
      lcnt_d  = lcnt_q;
      fired_d = fired_q;
      long_d  = 1'b0;
      if ((state_q == HELD || state_q == WAIT_UP) && state_d != IDLE_UP) begin
         if (!fired_q) begin
            lcnt_d = lcnt_q + 1'b1;
            if (lcnt_d == LONG_MAX) begin
               long_d  = 1'b1;
               fired_d = 1'b1;
            end
         end
      end else begin
         lcnt_d  = '0;
         fired_d = 1'b0;
      end
   end

   assign long_o = long_q;
`else
   logic unused_long_cfg;
   assign unused_long_cfg = ^LONG_CYCLES;
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Push-button input conditioner: NUM_KEYS independent channels, each with a
// two-flop synchroniser, counter debounce FSM and registered event pulses.
// Optional feature macro: KEY_LONG_PRESS_EN (one-cycle long-press pulse).
// Ports:
//   m_clk          in   system clock, rising edge
//   m_rst          in   synchronous active-high reset
//   m_key_raw      in   [NUM_KEYS] raw key pins, active-low, asynchronous
//   m_key_level    out  [NUM_KEYS] debounced level, active-low
//   m_key_press    out  [NUM_KEYS] one-cycle pulse on debounced 1->0
//   m_key_release  out  [NUM_KEYS] one-cycle pulse on debounced 0->1
//   m_key_long     out  [NUM_KEYS] one-cycle long-press pulse (0 if disabled)
// -----------------------------------------------------------------------------
module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic                m_clk,
   input  logic                m_rst,
   input  logic [NUM_KEYS-1:0] m_key_raw,
   output logic [NUM_KEYS-1:0] m_key_level,
   output logic [NUM_KEYS-1:0] m_key_press,
   output logic [NUM_KEYS-1:0] m_key_release,
   output logic [NUM_KEYS-1:0] m_key_long
);

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_cell (
         .m_clk     (m_clk),
         .m_rst     (m_rst),
         .key_raw_i (m_key_raw[k]),
         .level_o   (m_key_level[k]),
         .press_o   (m_key_press[k]),
         .release_o (m_key_release[k]),
         .long_o    (m_key_long[k])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

   localparam int NK = 3;

   logic          m_clk = 1'b0;
   logic          m_rst;
   logic [NK-1:0] m_key_raw;
   logic [NK-1:0] m_key_level, m_key_press, m_key_release, m_key_long;

   int n_cmp = 0;
   int n_err = 0;
   logic [NK-1:0] long_seen = '0;

   key_debounce #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (16)
   ) dut (
      .m_clk         (m_clk),
      .m_rst         (m_rst),
      .m_key_raw     (m_key_raw),
      .m_key_level   (m_key_level),
      .m_key_press   (m_key_press),
      .m_key_release (m_key_release),
      .m_key_long    (m_key_long)
   );

   always #5 m_clk = ~m_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge m_clk);
      #1;
      long_seen |= m_key_long;
   endtask

   // Raw change applied now is sampled at the next edge E0; the registered
   // press/release appears at E0+6, i.e. after 7 steps.
   task automatic expect_press(input string tag, input logic [NK-1:0] pmask,
                               input logic [NK-1:0] lvl_after);
      logic [NK-1:0] early;
      early = '0;
      repeat (6) begin
         step();
         early |= m_key_press | m_key_release;
      end
      chk({tag, "_early"}, 32'(early), 32'(0));
      step();
      chk({tag, "_press"}, 32'(m_key_press), 32'(pmask));
      chk({tag, "_level"}, 32'(m_key_level), 32'(lvl_after));
      step();
      chk({tag, "_clr"}, 32'(m_key_press), 32'(0));
   endtask

   initial begin : main
      logic [NK-1:0] acc_p, acc_r, acc_l;
      int            npulse;
      int            t_press, t_long, nlong;

      m_rst     = 1'b1;
      m_key_raw = 3'b111;
      step();
      step();
      chk("rst_level", 32'(m_key_level), 32'h7);
      chk("rst_pulses", 32'({m_key_press, m_key_release, m_key_long}), 32'h0);
      m_rst = 1'b0;

      // Idle for 50 cycles
      acc_p = '0; acc_r = '0; acc_l = 3'b111;
      repeat (50) begin
         step();
         acc_p |= m_key_press;
         acc_r |= m_key_release | m_key_long;
         acc_l &= m_key_level;
      end
      chk("idle_press", 32'(acc_p), 32'h0);
      chk("idle_rel_long", 32'(acc_r), 32'h0);
      chk("idle_level", 32'(acc_l), 32'h7);

      // Clean press on key0
      m_key_raw = 3'b110;
      expect_press("k0", 3'b001, 3'b110);

      // Bounce on key1: low 3, high 2, low 2, then high
      acc_p = '0; acc_l = 3'b111;
      m_key_raw = 3'b100; repeat (3) begin step(); acc_p |= m_key_press; acc_l &= m_key_level | 3'b001; end
      m_key_raw = 3'b110; repeat (2) begin step(); acc_p |= m_key_press; acc_l &= m_key_level | 3'b001; end
      m_key_raw = 3'b100; repeat (2) begin step(); acc_p |= m_key_press; acc_l &= m_key_level | 3'b001; end
      m_key_raw = 3'b110; repeat (8) begin step(); acc_p |= m_key_press; acc_l &= m_key_level | 3'b001; end
      chk("bounce_press", 32'(acc_p), 32'h0);
      chk("bounce_level", 32'(acc_l), 32'h7);

      // key1 held low 10 cycles -> exactly one press pulse
      m_key_raw = 3'b100;
      npulse = 0;
      repeat (10) begin
         step();
         if (m_key_press[1]) npulse++;
      end
      chk("k1_npress", 32'(npulse), 32'd1);
      chk("k1_level", 32'(m_key_level), 32'b100);

      // Release both: key0 and key1 return high together
      m_key_raw = 3'b111;
      repeat (6) step();
      chk("rel_early", 32'(m_key_release), 32'h0);
      step();
      chk("rel_pulse", 32'(m_key_release), 32'b011);
      chk("rel_level", 32'(m_key_level), 32'h7);
      chk("rel_nopress", 32'(m_key_press), 32'h0);
      step();
      chk("rel_clr", 32'(m_key_release), 32'h0);

      // Simultaneous press on keys 0 and 2
      m_key_raw = 3'b010;
      expect_press("k02", 3'b101, 3'b010);

      // Put key2 into WAIT_UP, then reset while key0 still held low
      m_key_raw = 3'b110;
      repeat (4) step();
      chk("wu_level", 32'(m_key_level), 32'b010);
      m_rst = 1'b1;
      step();
      chk("mid_rst_level", 32'(m_key_level), 32'h7);
      chk("mid_rst_pulses", 32'({m_key_press, m_key_release, m_key_long}), 32'h0);
      m_rst = 1'b0;
      expect_press("post_rst", 3'b001, 3'b110);

`ifdef KEY_LONG_PRESS_EN
      // key0 has just pressed (press pulse one step ago); release and redo
      // a fresh press to time the long pulse from the press pulse.
      m_key_raw = 3'b111;
      repeat (10) step();
      long_seen = '0;
      m_key_raw = 3'b110;
      t_press = -1; t_long = -1; nlong = 0;
      for (int c = 0; c < 47; c++) begin
         step();
         if (m_key_press[0]) t_press = c;
         if (m_key_long[0]) begin
            nlong++;
            t_long = c;
         end
      end
      chk("long_count", 32'(nlong), 32'd1);
      chk("long_delay", 32'(t_long - t_press), 32'd15);
      chk("long_other", 32'(long_seen[2:1]), 32'h0);
`else
      t_press = 0; t_long = 0; nlong = 0;
      m_key_raw = 3'b110;
      repeat (40) step();
      chk("long_off", 32'(long_seen), 32'h0);
      chk("long_off_level", 32'(m_key_level), 32'b110);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
